// File: rtl/pipelined_add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Provides chunk sizing, a parameter legality check and the flag bundle.
package pipelined_add_sub_pkg;

   typedef struct packed {
      logic c_out;
      logic ovf;
      logic zero;
   } flags_t;

   function automatic int chunk_w(input int width, input int stages);
      return (stages > 0) ? width / stages : width;
   endfunction

   function automatic bit dims_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) &&
             ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// Combinational CHUNK-bit slice adder used by every pipeline stage.
// Ports: a, b (chunk operands), cin -> sum (chunk result), cout (carry out).
module pipe_add_stage
   import pipelined_add_sub_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub, one CHUNK of the word per stage.
// Ports: CLK, RST (async high); IN_VALID/IN_READY with A, B, SUB, C_IN;
//        OUT_VALID/OUT_READY with S, C_OUT, OVF, ZERO (flags valid with S).
module pipelined_add_sub
   import pipelined_add_sub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SUB,
   input  logic             C_IN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] S,
   output logic             C_OUT,
   output logic             OVF,
   output logic             ZERO
);

   localparam int CHUNK = chunk_w(WIDTH, STAGES);
   localparam int LAST  = STAGES - 1;

   if (!dims_ok(WIDTH, STAGES)) begin : g_bad
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
   end

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             cin0;
   logic             ovf_nx;
   flags_t           fl_d;
   flags_t           fl_q;

   // Whole-pipe stall: everything moves together or nothing moves.
   assign advance  = ~OUT_VALID | OUT_READY;
   assign IN_READY = advance;

   assign b_eff = SUB ? ~B : B;
   assign cin0  = C_IN ^ SUB;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * CHUNK;
      localparam int BW = WIDTH - LO;

      logic [WIDTH-1:0] a_i;
      logic [WIDTH-1:0] a_nx;
      logic [WIDTH-1:0] a_q;
      logic [BW-1:0]    b_i;
      logic [CHUNK-1:0] sum;
      logic             c_i;
      logic             v_i;
      logic             cout;
      logic             v_q;

      if (k == 0) begin : g_in
         assign a_i = A;
         assign b_i = b_eff;
         assign c_i = cin0;
         assign v_i = IN_VALID;
      end else begin : g_in
         assign a_i = g_st[k-1].a_q;
         assign b_i = g_st[k-1].g_sk.b_q;
         assign c_i = g_st[k-1].g_sk.c_q;
         assign v_i = g_st[k-1].v_q;
      end

      pipe_add_stage #(
         .CHUNK (CHUNK)
      ) u_add (
         .a    (a_i[LO +: CHUNK]),
         .b    (b_i[CHUNK-1:0]),
         .cin  (c_i),
         .sum  (sum),
         .cout (cout)
      );

      // a_q carries finished sum chunks below and raw A chunks above.
      always_comb begin
         a_nx = a_i;
         a_nx[LO +: CHUNK] = sum;
      end

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            v_q <= 1'b0;
            a_q <= '0;
         end else if (advance) begin
            v_q <= v_i;
            if (v_i) a_q <= a_nx;
         end
      end

      // Skew: only the still-unused upper Beff chunks travel on.
      if (k < LAST) begin : g_sk
         logic [BW-CHUNK-1:0] b_q;
         logic                c_q;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               b_q <= '0;
               c_q <= 1'b0;
            end else if (advance && v_i) begin
               b_q <= b_i[BW-1:CHUNK];
               c_q <= cout;
            end
         end
      end
   end

   // Sign rule on the true operands of the top bit.
   always_comb begin
      ovf_nx =
         (g_st[LAST].a_i[WIDTH-1] == g_st[LAST].b_i[CHUNK-1]) &
         (g_st[LAST].sum[CHUNK-1] != g_st[LAST].a_i[WIDTH-1]);
   end

   always_comb begin
      fl_d       = '0;
      fl_d.c_out = g_st[LAST].cout;
      fl_d.ovf   = ovf_nx;
      fl_d.zero  = ~|g_st[LAST].a_nx;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fl_q <= '0;
      end else if (advance && g_st[LAST].v_i) begin
         fl_q <= fl_d;
      end
   end

   assign S         = g_st[LAST].a_q;
   assign OUT_VALID = g_st[LAST].v_q;
   assign C_OUT     = fl_q.c_out;
   assign OVF       = fl_q.ovf;
   assign ZERO      = fl_q.zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed vectors, backpressure, reset.
// Also sweeps (8,1), (8,8), (64,2) against a reference model.
module tb_pipelined_add_sub;

   typedef struct packed {
      logic        c;
      logic        o;
      logic        z;
      logic [63:0] s;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   int   sw_cnt = 0;
   logic sweep_go = 1'b0;

   initial forever #5 clk = ~clk;

   logic        iv, ir, sub, cin, ov, ordy, co, ovf, z;
   logic [31:0] a, b, s;

   pipelined_add_sub #(
      .WIDTH  (32),
      .STAGES (4)
   ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_VALID  (iv),
      .IN_READY  (ir),
      .A         (a),
      .B         (b),
      .SUB       (sub),
      .C_IN      (cin),
      .OUT_VALID (ov),
      .OUT_READY (ordy),
      .S         (s),
      .C_OUT     (co),
      .OVF       (ovf),
      .ZERO      (z)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic mark_done();
      sw_cnt++;
   endtask

   function automatic exp_t gold(input int w, input logic [63:0] a_,
                                 input logic [63:0] b_,
                                 input logic sub_, input logic cin_);
      exp_t        e;
      logic [63:0] m, am, be;
      logic [64:0] f;
      m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      am = a_ & m;
      be = (sub_ ? ~b_ : b_) & m;
      f  = {1'b0, am} + {1'b0, be} + {64'd0, cin_ ^ sub_};
      e.s = f[63:0] & m;
      e.c = f[w];
      e.z = (e.s == 64'd0);
      e.o = (am[w-1] == be[w-1]) && (e.s[w-1] != am[w-1]);
      return e;
   endfunction

   task automatic run_op(input logic [31:0] a_, input logic [31:0] b_,
                         input logic sub_, input logic cin_,
                         output int lat);
      a = a_; b = b_; sub = sub_; cin = cin_;
      iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      lat = 1;
      while (!ov && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic expect_res(input string t, input logic [31:0] s_,
                             input logic c_, input logic o_,
                             input logic z_, input int lat);
      chk({t, "_lat"}, lat, 4);
      chk({t, "_s"}, s, s_);
      chk({t, "_c"}, co, c_);
      chk({t, "_o"}, ovf, o_);
      chk({t, "_z"}, z, z_);
   endtask

   initial begin
      int          lat, idx, nout, cyc;
      logic        stall, in_x, out_x, stale;
      logic [31:0] held, va, vb;
      exp_t        e;
      exp_t        q[$];

      rst = 1'b1; iv = 1'b0; ordy = 1'b1;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      #2;
      chk("rst_ov", ov, 0);
      chk("rst_s", s, 0);
      chk("rst_ir", ir, 1);
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(32'h5, 32'h3, 1'b0, 1'b0, lat);
      expect_res("add", 32'h8, 1'b0, 1'b0, 1'b0, lat);
      run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
      expect_res("wrap", 32'h0, 1'b1, 1'b0, 1'b1, lat);
      run_op(32'h5, 32'h5, 1'b1, 1'b0, lat);
      expect_res("sub0", 32'h0, 1'b1, 1'b0, 1'b1, lat);
      run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
      expect_res("povf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, lat);
      run_op(32'h8000_0000, 32'h1, 1'b1, 1'b0, lat);
      expect_res("novf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, lat);
      run_op(32'h0, 32'h1, 1'b1, 1'b0, lat);
      expect_res("brw", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, lat);
      run_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b1, lat);
      expect_res("cin", 32'h0001_FFFF, 1'b0, 1'b0, 1'b0, lat);
      run_op(32'd10, 32'd3, 1'b1, 1'b1, lat);
      expect_res("bin", 32'd6, 1'b1, 1'b0, 1'b0, lat);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat);
      expect_res("nn", 32'h0, 1'b1, 1'b1, 1'b1, lat);
      @(posedge clk); #1;

      idx = 0; nout = 0; cyc = 0;
      while ((idx < 8 || q.size() > 0) && cyc < 300) begin
         cyc++;
         iv  = (idx < 8);
         va  = 32'h1357_9BDF * 32'(idx + 1);
         vb  = 32'hF0E1_D2C3 ^ (32'(idx) * 32'h0101_0101);
         a   = va; b = vb;
         sub = idx[0]; cin = idx[1];
         ordy = 1'($urandom_range(0, 1));
         #2;
         chk("bp_ready", ir, !(ov && !ordy));
         stall = ov && !ordy;
         held  = s;
         in_x  = iv && ir;
         out_x = ov && ordy;
         if (out_x) begin
            if (q.size() == 0) begin
               chk("bp_extra", 1, 0);
            end else begin
               e = q.pop_front();
               chk("bp_s", s, e.s);
               chk("bp_c", co, e.c);
               chk("bp_o", ovf, e.o);
               chk("bp_z", z, e.z);
            end
            nout++;
         end
         if (in_x) q.push_back(gold(32, 64'(va), 64'(vb), sub, cin));
         @(posedge clk); #1;
         if (in_x) idx++;
         if (stall) begin
            chk("bp_hold", s, held);
            chk("bp_hold_v", ov, 1);
         end
      end
      iv = 1'b0; ordy = 1'b1;
      chk("bp_count", nout, 8);

      iv = 1'b1; sub = 1'b0; cin = 1'b0;
      a = 32'h1; b = 32'h1;
      @(posedge clk); #1;
      a = 32'h2;
      @(posedge clk); #1;
      a = 32'h3;
      @(posedge clk); #1;
      iv = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("mid_ov", ov, 0);
      chk("mid_s", s, 0);
      chk("mid_z", z, 0);
      @(posedge clk); #3;
      rst = 1'b0;
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         stale |= ov;
      end
      chk("mid_stale", stale, 0);
      chk("mid_ir", ir, 1);
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
      expect_res("post", 32'h2345_6789, 1'b0, 1'b0, 1'b0, lat);
      @(posedge clk); #1;

      sweep_go = 1'b1;
      cyc = 0;
      while (sw_cnt < 3 && cyc < 30000) begin
         @(posedge clk);
         cyc++;
      end
      chk("sw_done", sw_cnt, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      localparam int W = (gi == 2) ? 64 : 8;
      localparam int S = (gi == 0) ? 1 : ((gi == 1) ? 8 : 2);

      logic [W-1:0] sa, sb, ss;
      logic         siv, sir, ssub, scin, sov, sordy, sco, sovf, sz;

      pipelined_add_sub #(
         .WIDTH  (W),
         .STAGES (S)
      ) u_dut (
         .CLK       (clk),
         .RST       (rst),
         .IN_VALID  (siv),
         .IN_READY  (sir),
         .A         (sa),
         .B         (sb),
         .SUB       (ssub),
         .C_IN      (scin),
         .OUT_VALID (sov),
         .OUT_READY (sordy),
         .S         (ss),
         .C_OUT     (sco),
         .OVF       (sovf),
         .ZERO      (sz)
      );

      initial begin
         exp_t        q[$];
         exp_t        e;
         logic [63:0] r;
         int          sent, cyc, lat;
         logic        in_x, out_x;

         siv = 1'b0; sordy = 1'b1;
         sa = '0; sb = '0; ssub = 1'b0; scin = 1'b0;
         sent = 0; cyc = 0;
         wait (sweep_go);
         @(posedge clk); #1;

         r = {$urandom, $urandom}; sa = r[W-1:0];
         r = {$urandom, $urandom}; sb = r[W-1:0];
         ssub = 1'($urandom_range(0, 1));
         scin = 1'($urandom_range(0, 1));
         e = gold(W, 64'(sa), 64'(sb), ssub, scin);
         siv = 1'b1;
         @(posedge clk); #1;
         siv = 1'b0;
         lat = 1;
         while (!sov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
         end
         chk("sw_lat", lat, S);
         chk("sw_lat_s", 64'(ss), e.s);
         @(posedge clk); #1;

         while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            cyc++;
            if (!siv && sent < 1000) begin
               r = {$urandom, $urandom}; sa = r[W-1:0];
               r = {$urandom, $urandom}; sb = r[W-1:0];
               ssub = 1'($urandom_range(0, 1));
               scin = 1'($urandom_range(0, 1));
               siv  = 1'b1;
            end
            sordy = 1'($urandom_range(0, 1));
            #2;
            in_x  = siv && sir;
            out_x = sov && sordy;
            if (out_x) begin
               if (q.size() == 0) begin
                  chk("sw_extra", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("sw_s", 64'(ss), e.s);
                  chk("sw_c", sco, e.c);
                  chk("sw_o", sovf, e.o);
                  chk("sw_z", sz, e.z);
               end
            end
            if (in_x) q.push_back(gold(W, 64'(sa), 64'(sb), ssub, scin));
            @(posedge clk); #1;
            if (in_x) begin
               sent++;
               siv = 1'b0;
            end
         end
         chk("sw_drain", q.size() + 1000 - sent, 0);
         siv = 1'b0; sordy = 1'b1;
         mark_done();
      end
   end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the multi-cycle datapath variant and for multiplier/divider helpers.
- Splits a WIDTH-bit add or subtract into STAGES equal chunks, one chunk per pipeline stage. The carry ripples stage to stage through registers.
- Uses valid/ready handshakes on both sides, with full backpressure. Produces carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and chunks. Range 1..WIDTH.
- CHUNK, WIDTH/STAGES, derived bits per stage. Not overridable.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  operands present this cycle
- IN_READY  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- SUB  input  1  0 = A+B+C_IN; 1 = A-B-C_IN
- C_IN  input  1  carry-in (add) or borrow-in (sub)
- OUT_VALID  output  1  result present
- OUT_READY  input  1  consumer accepts result
- S  output  WIDTH  result
- C_OUT  output  1  carry out of bit WIDTH-1; in SUB mode 1 = no borrow
- OVF  output  1  signed overflow
- ZERO  output  1  S == 0

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high. On RST, every stage valid bit, S, C_OUT, OVF, ZERO and OUT_VALID go to 0 immediately. In-flight operations are discarded, never emitted.
- Operation:
  - Effective operand is Beff = SUB ? ~B : B.
  - Effective carry-in is cin = C_IN ^ SUB.
  - Result = A + Beff + cin, mod 2^WIDTH.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and Beff with the carry registered by stage k-1. Stage 0 uses cin.
  - Registers its sum chunk, its carry, the sum chunks of lower stages, and the not-yet-used upper chunks of A/Beff (skew registers).
- Latency and throughput:
  - Latency is exactly STAGES cycles from an accepted input to OUT_VALID, with OUT_READY held high.
  - Throughput is one op/cycle.
- Advance rule:
  - advance = ~OUT_VALID | OUT_READY.
  - IN_READY = advance, driven combinationally. It does not depend on IN_VALID.
- Transfers:
  - Input transfer: IN_VALID & IN_READY.
  - Output transfer: OUT_VALID & OUT_READY.
- Stall behaviour:
  - When advance=0, all stage registers, valid bits and outputs hold.
  - S, C_OUT, OVF and ZERO stay stable while OUT_VALID=1 and OUT_READY=0.
- Bubbles:
  - A stage whose valid bit is 0 may load on advance even if downstream is full. Whole-pipe stall only is acceptable; no bubble collapsing is required.
  - Bubbles propagate as valid=0.
- Flags, registered with S in the final stage:
  - C_OUT = carry out of the top chunk.
  - OVF = (A[W-1] == Beff[W-1]) & (S[W-1] != A[W-1]).
  - ZERO = ~|S.
- Flags when OUT_VALID=0: outputs hold their last value. The bench must ignore them.
- STAGES=1: a single registered adder with latency 1.
- Simultaneous input and output transfer in the same cycle: both occur, with no loss or duplication.
- Wrap-around: the sum wraps modulo 2^WIDTH and C_OUT reports the carry.
- RST asserted during a stall: the pipe empties and IN_READY=1 after release.

Decomposition:
- Shared package (datapath pkg):
  - Localparam helper computing CHUNK.
  - Elaboration check that WIDTH % STAGES == 0 and STAGES >= 1.
  - Flag-bundle struct {c_out, ovf, zero}.
- Sub-module pipe_add_stage:
  - Purely combinational CHUNK-bit adder: A chunk, B chunk, cin -> sum, cout, plus top-bit carry-in for OVF.
  - Instantiated STAGES times by generate.
  - Registers and the handshake live in the top.

Test Plan:
- W=32,S=4, single op: A=0x0000_0005, B=3, SUB=0, C_IN=0, OUT_READY=1 -> 4 cycles later S=0x8, C_OUT=0, OVF=0, ZERO=0.
- Carry across all chunks: A=0xFFFF_FFFF, B=1, SUB=0 -> S=0, C_OUT=1, ZERO=1, OVF=0. With SUB=1, A=5, B=5, C_IN=0 -> S=0, C_OUT=1, ZERO=1.
- Signed overflow and borrow:
  - A=0x7FFF_FFFF, B=1, add -> S=0x8000_0000, OVF=1.
  - A=0x8000_0000, B=1, sub -> S=0x7FFF_FFFF, OVF=1.
  - A=0, B=1, sub -> S=0xFFFF_FFFF, C_OUT=0.
- Backpressure: stream 8 ops back-to-back with OUT_READY random 50% -> results emerge in order, each equals the golden model, none dropped or duplicated. IN_READY=0 exactly when OUT_VALID=1 and OUT_READY=0. Output held stable during stall.
- Reset mid-flight: accept 3 ops, assert RST asynchronously between clock edges -> OUT_VALID=0 and S=0 immediately. After release no stale result appears; a new op returns after 4 cycles.
- Parameter sweep: (WIDTH,STAGES) = (8,1), (8,8), (64,2), 1000 random ops each with C_IN/SUB random -> match the golden model; latency equals STAGES.
